poly_tone_synth: RTL and testbench

- Polyphonic successor to the single-voice square-wave note generator: VOICES independent square-wave oscillators, each retuned through a valid/ready note-request interface.
- Voice outputs are summed and converted to the single-bit AIN drive by a first-order sigma-delta modulator.
- Sits between the key-scan/control logic and the mono audio amplifier pins.
- Adds four things the single-voice block lacks: glitch-free retune at waveform edges, clean note-off at a low level, per-voice activity status, and reset.

---
 rtl/synth_pkg.sv | 33 +++
 rtl/tone_voice.sv | 150 +++++++++++++++
 rtl/poly_tone_synth.sv | 151 +++++++++++++++
 tb/tb_poly_tone_synth.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the polyphonic square-wave synthesiser.
package synth_pkg;

    localparam int NOTE_W = 3;
    localparam int OCT_W  = 3;
    localparam int BASE_W = 32;

    // Note code that silences a voice instead of tuning it.
    localparam logic [NOTE_W-1:0] NOTE_OFF = 3'd0;

    typedef enum logic [1:0] {
        V_IDLE    = 2'd0,
        V_RUN     = 2'd1,
        V_RELEASE = 2'd2
    } voice_state_e;

    // Half-period in 100 MHz clocks of notes C..B in the base octave.
    function automatic logic [BASE_W-1:0] note_half_period(input logic [NOTE_W-1:0] note);
        logic [BASE_W-1:0] hp;
        case (note)
            3'd1:    hp = 32'd1528902;
            3'd2:    hp = 32'd1362097;
            3'd3:    hp = 32'd1213491;
            3'd4:    hp = 32'd1145383;
            3'd5:    hp = 32'd1020420;
            3'd6:    hp = 32'd909091;
            3'd7:    hp = 32'd809908;
            default: hp = 32'd0;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave oscillator voice: half-period counter, active/pending
// period registers and an IDLE/RUN/RELEASE state machine. Period changes
// and note-off only take effect on a waveform edge so the output never glitches.
module tone_voice
    import synth_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmt_valid_i,
    input  logic             cmt_off_i,
    input  logic [DIV_W-1:0] cmt_period_i,
    output logic             sq_o,
    output logic             active_o
);

    voice_state_e     state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             sq_q, sq_d;
    logic             active_q, active_d;

    logic             terminal_s;
    logic             note_on_s;
    logic             note_off_s;
    logic             tog_sq_s;
    logic [DIV_W-1:0] tog_cnt_s;
    logic [DIV_W-1:0] tog_period_s;
    logic             tog_pvld_s;

    // Next-state logic: running step shared by RUN and a cancelled RELEASE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sq_d       = sq_q;

        terminal_s = (cnt_q >= period_q);
        note_on_s  = cmt_valid_i & ~cmt_off_i;
        note_off_s = cmt_valid_i & cmt_off_i;

        // A terminal count toggles the wave and adopts any pending period
        // that existed before this cycle's commit.
        if (terminal_s) begin
            tog_sq_s  = ~sq_q;
            tog_cnt_s = {{(DIV_W-1){1'b0}}, 1'b1};
            if (pend_vld_q) begin
                tog_period_s = pend_q;
                tog_pvld_s   = 1'b0;
            end else begin
                tog_period_s = period_q;
                tog_pvld_s   = 1'b0;
            end
        end else begin
            tog_sq_s     = sq_q;
            tog_cnt_s    = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            tog_period_s = period_q;
            tog_pvld_s   = pend_vld_q;
        end

        case (state_q)
            V_IDLE: begin
                if (note_on_s) begin
                    period_d   = cmt_period_i;
                    cnt_d      = {{(DIV_W-1){1'b0}}, 1'b1};
                    sq_d       = 1'b1;
                    pend_vld_d = 1'b0;
                    state_d    = V_RUN;
                end else begin
                    cnt_d      = '0;
                    sq_d       = 1'b0;
                    pend_vld_d = 1'b0;
                    state_d    = V_IDLE;
                end
            end
            V_RUN: begin
                sq_d       = tog_sq_s;
                cnt_d      = tog_cnt_s;
                period_d   = tog_period_s;
                pend_vld_d = tog_pvld_s;
                if (note_on_s) begin
                    pend_d     = cmt_period_i;
                    pend_vld_d = 1'b1;
                    state_d    = V_RUN;
                end else if (note_off_s) begin
                    state_d = V_RELEASE;
                end else begin
                    state_d = V_RUN;
                end
            end
            V_RELEASE: begin
                if (note_on_s) begin
                    sq_d       = tog_sq_s;
                    cnt_d      = tog_cnt_s;
                    period_d   = tog_period_s;
                    pend_d     = cmt_period_i;
                    pend_vld_d = 1'b1;
                    state_d    = V_RUN;
                end else if (terminal_s) begin
                    // Falling edge or already low: either way finish low.
                    sq_d       = 1'b0;
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    state_d    = V_IDLE;
                end else begin
                    cnt_d   = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
                    state_d = V_RELEASE;
                end
            end
            default: begin
                sq_d       = 1'b0;
                cnt_d      = '0;
                pend_vld_d = 1'b0;
                state_d    = V_IDLE;
            end
        endcase

        active_d = (state_d != V_IDLE);
    end

    // Voice state registers; activity flag is registered with the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= V_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sq_q       <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sq_q       <= sq_d;
            active_q   <= active_d;
        end
    end

    assign sq_o     = sq_q;
    assign active_o = active_q;

endmodule

// File: rtl/poly_tone_synth.sv
// Polyphonic square-wave synthesiser: a two-stage note request pipeline
// (latch, then period lookup/shift/clamp) feeds VOICES oscillators whose
// outputs are mixed into one bit by a first-order sigma-delta modulator.
module poly_tone_synth
    import synth_pkg::*;
#(
    parameter int  VOICES     = 4,
    parameter int  DIV_W      = 32,
    parameter int  MIN_PERIOD = 2,
    localparam int VOICE_W    = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic               clk_100M,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [VOICE_W-1:0] req_voice,
    input  logic [OCT_W-1:0]   req_octave,
    input  logic [NOTE_W-1:0]  req_note,
    output logic [VOICES-1:0]  voice_active,
    output logic               AIN,
    output logic               GAIN,
    output logic               NC,
    output logic               ACTIVE
);

    localparam int               ACC_W    = $clog2(VOICES) + 1;
    localparam logic [DIV_W-1:0] MIN_P    = DIV_W'(MIN_PERIOD);
    localparam logic [ACC_W-1:0] VOICES_A = ACC_W'(VOICES);

    logic               ready_q, ready_d;
    logic               a_vld_q, a_vld_d;
    logic [VOICE_W-1:0] a_voice_q, a_voice_d;
    logic [OCT_W-1:0]   a_oct_q, a_oct_d;
    logic [NOTE_W-1:0]  a_note_q, a_note_d;
    logic               b_vld_q, b_vld_d;
    logic [VOICE_W-1:0] b_voice_q, b_voice_d;
    logic               b_off_q, b_off_d;
    logic [DIV_W-1:0]   b_period_q, b_period_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ain_q, ain_d;

    logic               accept_s;
    logic [DIV_W-1:0]   base_s;
    logic [DIV_W-1:0]   shift_s;
    logic [DIV_W-1:0]   clamp_s;
    logic [ACC_W-1:0]   pop_s;
    logic [ACC_W-1:0]   acc_n_s;

    logic [VOICES-1:0]  cmt_vld_s;
    logic [VOICES-1:0]  sq_s;
    logic [VOICES-1:0]  active_s;

    // Request pipeline: accept/latch in stage A, period computation in stage B.
    always_comb begin
        accept_s = req_valid & ready_q;
        ready_d  = ~accept_s;
        a_vld_d  = accept_s;
        if (accept_s) begin
            a_voice_d = req_voice;
            a_oct_d   = req_octave;
            a_note_d  = req_note;
        end else begin
            a_voice_d = a_voice_q;
            a_oct_d   = a_oct_q;
            a_note_d  = a_note_q;
        end

        base_s  = DIV_W'(note_half_period(a_note_q));
        shift_s = base_s >> a_oct_q;
        if (shift_s < MIN_P) begin
            clamp_s = MIN_P;
        end else begin
            clamp_s = shift_s;
        end

        b_vld_d    = a_vld_q;
        b_voice_d  = a_voice_q;
        b_off_d    = (a_note_q == NOTE_OFF);
        b_period_d = clamp_s;
    end

    // Sigma-delta mixer: emit a 1 whenever the running sum crosses VOICES.
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < VOICES; i++) begin
            pop_s = pop_s + ACC_W'(sq_s[i]);
        end
        acc_n_s = acc_q + pop_s;
        if (acc_n_s >= VOICES_A) begin
            ain_d = 1'b1;
            acc_d = acc_n_s - VOICES_A;
        end else begin
            ain_d = 1'b0;
            acc_d = acc_n_s;
        end
    end

    // Pipeline and mixer registers; reset drops any in-flight request.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            a_vld_q    <= 1'b0;
            a_voice_q  <= '0;
            a_oct_q    <= '0;
            a_note_q   <= '0;
            b_vld_q    <= 1'b0;
            b_voice_q  <= '0;
            b_off_q    <= 1'b0;
            b_period_q <= '0;
            acc_q      <= '0;
            ain_q      <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            a_vld_q    <= a_vld_d;
            a_voice_q  <= a_voice_d;
            a_oct_q    <= a_oct_d;
            a_note_q   <= a_note_d;
            b_vld_q    <= b_vld_d;
            b_voice_q  <= b_voice_d;
            b_off_q    <= b_off_d;
            b_period_q <= b_period_d;
            acc_q      <= acc_d;
            ain_q      <= ain_d;
        end
    end

    // An index with no matching voice simply commits nowhere.
    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        assign cmt_vld_s[g] = b_vld_q & (b_voice_q == VOICE_W'(g));

        tone_voice #(
            .DIV_W(DIV_W)
        ) u_voice (
            .clk_i        (clk_100M),
            .rst_ni       (rst_n),
            .cmt_valid_i  (cmt_vld_s[g]),
            .cmt_off_i    (b_off_q),
            .cmt_period_i (b_period_q),
            .sq_o         (sq_s[g]),
            .active_o     (active_s[g])
        );
    end

    assign req_ready    = ready_q;
    assign voice_active = active_s;
    assign AIN          = ain_q;
    assign GAIN         = 1'b1;
    assign NC           = 1'b0;
    assign ACTIVE       = 1'b1;

endmodule

// File: tb/tb_poly_tone_synth.sv
// Bench for poly_tone_synth: a single-voice instance with an edge-driven
// scoreboard on AIN run lengths, a four-voice instance for handshake/mixer/
// reset, and a pair of single-voice instances for the period clamp.
module tb_poly_tone_synth;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- single-voice instance ----------------
    logic       rst1_n = 1'b0;
    logic       v1_valid = 1'b0;
    logic [0:0] v1_voice = 1'b0;
    logic [2:0] v1_oct = 3'd0;
    logic [2:0] v1_note = 3'd0;
    logic       v1_ready, ain1, gain1, nc1, act1;
    logic [0:0] v1_active;

    poly_tone_synth #(.VOICES(1)) dut1 (
        .clk_100M(clk), .rst_n(rst1_n), .req_valid(v1_valid), .req_ready(v1_ready),
        .req_voice(v1_voice), .req_octave(v1_oct), .req_note(v1_note),
        .voice_active(v1_active), .AIN(ain1), .GAIN(gain1), .NC(nc1), .ACTIVE(act1)
    );

    // ---------------- four-voice instance ----------------
    logic       rst4_n = 1'b0;
    logic       v4_valid = 1'b0;
    logic [1:0] v4_voice = 2'd0;
    logic [2:0] v4_oct = 3'd0;
    logic [2:0] v4_note = 3'd0;
    logic       v4_ready, ain4, gain4, nc4, act4;
    logic [3:0] v4_active;

    poly_tone_synth #(.VOICES(4)) dut4 (
        .clk_100M(clk), .rst_n(rst4_n), .req_valid(v4_valid), .req_ready(v4_ready),
        .req_voice(v4_voice), .req_octave(v4_oct), .req_note(v4_note),
        .voice_active(v4_active), .AIN(ain4), .GAIN(gain4), .NC(nc4), .ACTIVE(act4)
    );

    // ---------------- clamp pair (shared stimulus) ----------------
    logic       rstk_n = 1'b0;
    logic       vk_valid = 1'b0;
    logic [0:0] vk_voice = 1'b0;
    logic [2:0] vk_oct = 3'd0;
    logic [2:0] vk_note = 3'd0;
    logic       k_ready, ain_k, gain_k, nc_k, act_k;
    logic       c_ready, ain_c, gain_c, nc_c, act_c;
    logic [0:0] k_active, c_active;

    poly_tone_synth #(.VOICES(1), .MIN_PERIOD(2)) dutk (
        .clk_100M(clk), .rst_n(rstk_n), .req_valid(vk_valid), .req_ready(k_ready),
        .req_voice(vk_voice), .req_octave(vk_oct), .req_note(vk_note),
        .voice_active(k_active), .AIN(ain_k), .GAIN(gain_k), .NC(nc_k), .ACTIVE(act_k)
    );

    poly_tone_synth #(.VOICES(1), .MIN_PERIOD(8000)) dutc (
        .clk_100M(clk), .rst_n(rstk_n), .req_valid(vk_valid), .req_ready(c_ready),
        .req_voice(vk_voice), .req_octave(vk_oct), .req_note(vk_note),
        .voice_active(c_active), .AIN(ain_c), .GAIN(gain_c), .NC(nc_c), .ACTIVE(act_c)
    );

    // ---------------- AIN run-length scoreboard for dut1 ----------------
    // Each AIN edge pops one expected length of the run it ends; -1 = don't care.
    int   exp_q[$];
    int   last_edge = 0;
    logic ain1_prev = 1'b0;

    always @(negedge clk) begin
        if (ain1 !== ain1_prev) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL ain1_edge: unexpected edge to %b at cycle %0d, expected none", ain1, cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e >= 0) check("ain1_run", cyc - last_edge, e);
            end
            last_edge = cyc;
            ain1_prev = ain1;
        end
    end

    // ---------------- helpers ----------------
    task automatic send1(input logic [0:0] v, input logic [2:0] oct, input logic [2:0] note);
        int n = 0;
        @(negedge clk);
        v1_valid = 1'b1; v1_voice = v; v1_oct = oct; v1_note = note;
        while (!v1_ready && n < 20) begin @(negedge clk); n++; end
        check("send1_ready", v1_ready, 1);
        @(negedge clk);
        v1_valid = 1'b0;
    endtask

    task automatic send4(input logic [1:0] v, input logic [2:0] oct, input logic [2:0] note);
        int n = 0;
        @(negedge clk);
        v4_valid = 1'b1; v4_voice = v; v4_oct = oct; v4_note = note;
        while (!v4_ready && n < 20) begin @(negedge clk); n++; end
        check("send4_ready", v4_ready, 1);
        @(negedge clk);
        v4_valid = 1'b0;
    endtask

    task automatic sendk(input logic [0:0] v, input logic [2:0] oct, input logic [2:0] note);
        int n = 0;
        @(negedge clk);
        vk_valid = 1'b1; vk_voice = v; vk_oct = oct; vk_note = note;
        while (!k_ready && n < 20) begin @(negedge clk); n++; end
        check("sendk_ready", k_ready, 1);
        @(negedge clk);
        vk_valid = 1'b0;
    endtask

    task automatic wait_ain1(input logic val, input int budget, input string name);
        int n = 0;
        while (ain1 !== val && n < budget) begin @(negedge clk); n++; end
        check(name, ain1, val);
    endtask

    // ---------------- single-voice sequence ----------------
    task automatic seq1();
        repeat (2) @(negedge clk);
        check("rst1_ready", v1_ready, 0);
        check("rst1_ain", ain1, 0);
        check("rst1_active", v1_active, 0);
        check("gain1", gain1, 1);
        check("nc1", nc1, 0);
        check("act1", act1, 1);
        rst1_n = 1'b1;
        @(negedge clk);
        check("rst1_ready_after", v1_ready, 1);

        // Latency: A octave 7, accept at T, sq at T+2, AIN at T+3.
        exp_q.push_back(-1);
        exp_q.push_back(7102);
        send1(1'b0, 3'd7, 3'd6);
        check("lat_ready_drop", v1_ready, 0);
        @(negedge clk);
        check("lat_ready_back", v1_ready, 1);
        check("lat_active_t1", v1_active, 0);
        check("lat_ain_t1", ain1, 0);
        @(negedge clk);
        check("lat_active_t2", v1_active, 1);
        check("lat_ain_t2", ain1, 0);
        @(negedge clk);
        check("lat_ain_t3", ain1, 1);

        // Retune to C mid-high: first half stays 7102, then 11944.
        repeat (1000) @(negedge clk);
        exp_q.push_back(11944);
        send1(1'b0, 3'd7, 3'd1);
        wait_ain1(1'b0, 8000, "wait_fall_a");

        // Retune to E mid-low: C half completes, then 9480.
        repeat (2000) @(negedge clk);
        exp_q.push_back(9480);
        send1(1'b0, 3'd7, 3'd3);
        wait_ain1(1'b1, 12000, "wait_rise_c");
        wait_ain1(1'b0, 10000, "wait_fall_e");

        // Note-off while low: no further high pulse, voice goes idle.
        repeat (1000) @(negedge clk);
        send1(1'b0, 3'd7, 3'd0);
        check("off_low_still_active", v1_active, 1);
        repeat (9480) @(negedge clk);
        check("off_low_idle", v1_active, 0);
        check("off_low_ain", ain1, 0);
        check("off_low_queue", exp_q.size(), 0);

        // Note-off while high: falls at next terminal, nothing afterwards.
        exp_q.push_back(-1);
        exp_q.push_back(7102);
        send1(1'b0, 3'd7, 3'd6);
        wait_ain1(1'b1, 10, "wait_rise_a2");
        repeat (500) @(negedge clk);
        send1(1'b0, 3'd7, 3'd0);
        check("off_high_still_active", v1_active, 1);
        wait_ain1(1'b0, 8000, "wait_fall_a2");
        check("off_high_active_clear", v1_active, 0);
        repeat (8000) @(negedge clk);
        check("off_high_idle", v1_active, 0);
        check("off_high_ain", ain1, 0);
        check("off_high_queue", exp_q.size(), 0);
    endtask

    // ---------------- four-voice sequence ----------------
    task automatic seq4();
        int   nacc;
        int   ones;
        int   alt_bad;
        logic r;
        logic prev;
        repeat (2) @(negedge clk);
        check("gain4", gain4, 1);
        check("nc4", nc4, 0);
        check("act4", act4, 1);
        rst4_n = 1'b1;
        @(negedge clk);
        check("rst4_ready_after", v4_ready, 1);

        // Handshake: valid held six cycles, voice index advanced per accept.
        nacc = 0;
        v4_valid = 1'b1; v4_voice = 2'd0; v4_oct = 3'd7; v4_note = 3'd7;
        for (int i = 0; i < 6; i++) begin
            r = v4_ready;
            check("hs_ready_pattern", r, (i % 2 == 0) ? 1 : 0);
            if (r) nacc++;
            @(negedge clk);
            if (r) v4_voice = v4_voice + 2'd1;
        end
        v4_valid = 1'b0;
        check("hs_accepts", nacc, 3);
        repeat (3) @(negedge clk);
        check("hs_active", v4_active, 4'b0111);

        // All four voices high: AIN stays 1.
        send4(2'd3, 3'd7, 3'd7);
        repeat (10) @(negedge clk);
        check("all4_active", v4_active, 4'b1111);
        ones = 0;
        for (int i = 0; i < 100; i++) begin
            if (ain4 === 1'b1) ones++;
            @(negedge clk);
        end
        check("all4_density", ones, 100);

        // Asynchronous reset mid-tone.
        #2;
        rst4_n = 1'b0;
        #1;
        check("arst_ready", v4_ready, 0);
        check("arst_ain", ain4, 0);
        check("arst_active", v4_active, 0);
        @(negedge clk);
        @(negedge clk);
        rst4_n = 1'b1;
        check("arst_ready_release", v4_ready, 0);
        @(negedge clk);
        check("arst_ready_next", v4_ready, 1);

        // Two voices high: density 2/4, strictly alternating.
        send4(2'd0, 3'd7, 3'd7);
        send4(2'd1, 3'd7, 3'd7);
        repeat (10) @(negedge clk);
        check("two_active", v4_active, 4'b0011);
        ones = 0;
        alt_bad = 0;
        prev = ~ain4;
        for (int i = 0; i < 100; i++) begin
            if (ain4 === 1'b1) ones++;
            if (ain4 === prev) alt_bad++;
            prev = ain4;
            @(negedge clk);
        end
        check("two_density", ones, 50);
        check("two_alternation_errors", alt_bad, 0);
    endtask

    // ---------------- clamp sequence ----------------
    task automatic seqk();
        int lk;
        int lc;
        int t0;
        int n;
        repeat (2) @(negedge clk);
        check("gaink", gain_k, 1);
        check("nck", nc_k, 0);
        check("actk", act_k, 1);
        check("gainc", gain_c, 1);
        check("ncc", nc_c, 0);
        check("actc", act_c, 1);
        rstk_n = 1'b1;
        @(negedge clk);
        check("rstk_ready_after", k_ready, 1);
        check("rstc_ready_after", c_ready, 1);

        // Out-of-range voice index: accepted, no voice starts.
        sendk(1'b1, 3'd7, 3'd6);
        repeat (5) @(negedge clk);
        check("oor_active", k_active, 0);
        check("oor_ain", ain_k, 0);

        // Note B octave 7: 6327 unclamped, 8000 with MIN_PERIOD 8000.
        sendk(1'b0, 3'd7, 3'd7);
        n = 0;
        while (ain_k !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("clamp_rise_k", ain_k, 1);
        check("clamp_rise_c", ain_c, 1);
        t0 = cyc;
        lk = -1;
        lc = -1;
        n = 0;
        while ((lk < 0 || lc < 0) && n < 9000) begin
            @(negedge clk);
            n++;
            if (lk < 0 && ain_k === 1'b0) lk = cyc - t0;
            if (lc < 0 && ain_c === 1'b0) lc = cyc - t0;
        end
        check("noclamp_half", lk, 6327);
        check("clamp_half", lc, 8000);
        check("clamp_active_c", c_active, 1);
    endtask

    initial begin
        fork
            seq1();
            seq4();
            seqk();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

endmodule
